my_processor_timer_host: RTL and testbench
==========================================

MY_PROCESSOR_TIMER_HOST -- requirements
Module: my_processor_timer_host

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset:
- clk  input  1  sole clock; all state changes on its rising edge
- reset_n  input  1  asynchronous, active-low reset
REQ-002 The module SHALL have the following host-side ports:
- start  input  1  one-cycle pulse; program and start the timer
- stop  input  1  one-cycle pulse; stop the running timer
- period  input  32  timer period, sampled when start is accepted
- busy  output  1  high in every state except IDLE
- tick  output  1  one-cycle pulse per serviced timeout
- tick_count  output  16  number of serviced timeouts
- snapshot  output  32  last captured counter snapshot
REQ-003 The module SHALL have the following Avalon-MM master and interrupt ports:
- avm_address  output  3  timer register index
- avm_chipselect  output  1  bus access strobe
- avm_write_n  output  1  low on a write access
- avm_writedata  output  16  write data
- avm_readdata  input  16  registered read data, valid one cycle after the read access
- irq_in  input  1  level timeout interrupt from the timer

Function
REQ-004 Each bus access SHALL occupy exactly one cycle with avm_chipselect=1; between accesses the bus SHALL idle at chipselect=0, write_n=1, address=0, writedata=0.
REQ-005 The FSM SHALL use these states: IDLE, WR_PL, WR_PH, WR_CTRL, RUN, CLR_ST, WR_STOP, plus SNAP_WR, RD_L, RD_H and RD_CAP when snapshots are compiled in.
REQ-006 In IDLE, a start pulse SHALL latch period and move to WR_PL; a stop pulse in IDLE SHALL be ignored.
REQ-007 WR_PL SHALL write period[15:0] to address 2, then go to WR_PH.
REQ-008 WR_PH SHALL write period[31:16] to address 3, then go to WR_CTRL.
REQ-009 WR_CTRL SHALL write 0x0007 (ITO|CONT|START) to address 1, then go to RUN.
REQ-010 Start to first bus write SHALL take 1 cycle; the start-to-RUN programming sequence SHALL take 4 cycles.
REQ-011 In RUN, irq_in=1 SHALL move to CLR_ST.
REQ-012 CLR_ST SHALL write 0x0000 to address 0 (clear timeout), pulse tick for one cycle, and increment tick_count modulo 2^16 (0xFFFF -> 0x0000).
REQ-013 From CLR_ST the FSM SHALL go to SNAP_WR when snapshots are enabled, otherwise to RUN.
REQ-014 After CLR_ST the FSM SHALL ignore irq_in for one cycle in RUN, because irq deasserts one cycle after the status write.
REQ-015 A stop pulse in any non-IDLE state SHALL be latched into a pending flag.
REQ-016 In RUN with the pending flag set and irq_in=0, the FSM SHALL enter WR_STOP, which writes 0x0008 to address 1, clears the flag, and returns to IDLE.
REQ-017 When irq_in and a pending stop coincide in RUN, the IRQ SHALL be serviced first and the stop taken on the next eligible RUN cycle.
REQ-018 A start pulse while busy=1 SHALL be ignored.
REQ-019 irq_in outside RUN SHALL be ignored; it remains asserted and is serviced on RUN entry.

Reset
REQ-020 Asserting reset_n low SHALL immediately force the FSM to IDLE and clear the pending stop flag.
REQ-021 On reset, outputs SHALL take these values: busy=0, tick=0, tick_count=0, snapshot=0, avm_chipselect=0, avm_write_n=1, avm_address=0, avm_writedata=0.
REQ-022 Reset mid-sequence SHALL abandon the sequence with no further bus access; the timer's own state is not restored.

Configuration
REQ-023 Macro TIMER_HOST_SNAPSHOT_EN defined: after CLR_ST, snapshots SHALL be captured by the following sequence:
- SNAP_WR: write 0x0000 to address 4
- RD_L: read address 4
- RD_H: read address 5, capturing avm_readdata into snapshot[15:0]
- RD_CAP: capture avm_readdata into snapshot[31:16], then return to RUN
REQ-024 Macro TIMER_HOST_SNAPSHOT_EN undefined: the snapshot states SHALL be absent, snapshot SHALL be tied to 0, and addresses 4 and 5 SHALL never be accessed.

Verification
REQ-025 Bench scenarios SHALL include:
- Start with period=0x0001_86A0 -> bus writes (2,0x86A0),(3,0x0001),(1,0x0007) on consecutive cycles; busy=1 from the cycle after start.
- irq_in asserted in RUN -> next cycle write (0,0x0000); tick pulses once; tick_count increments 0->1; irq dropped one cycle later causes no second service.
- tick_count preloaded to 0xFFFF via 65535 IRQs, then one more IRQ -> tick_count=0x0000.
- stop during WR_PH -> sequence completes through WR_CTRL, then write (1,0x0008), then IDLE with busy=0.
- irq_in and stop in the same RUN cycle -> CLR_ST write first, then WR_STOP write.
- With TIMER_HOST_SNAPSHOT_EN, readdata model returns 0x1234 then 0xABCD -> snapshot=0xABCD_1234; reset asserted during RD_H -> bus idles immediately and all outputs equal their reset values.

Source files
------------

// File: rtl/my_processor_timer_host.sv
// Timer host: programs an Avalon-MM interval timer, services its timeout IRQ and counts ticks.
// Optional counter-snapshot capture after each timeout is built when TIMER_HOST_SNAPSHOT_EN is defined.
module my_processor_timer_host (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        stop,
    input  logic [31:0] period,
    output logic        busy,
    output logic        tick,
    output logic [15:0] tick_count,
    output logic [31:0] snapshot,
    output logic [2:0]  avm_address,
    output logic        avm_chipselect,
    output logic        avm_write_n,
    output logic [15:0] avm_writedata,
    input  logic [15:0] avm_readdata,
    input  logic        irq_in
);

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        WR_PL   = 4'd1,
        WR_PH   = 4'd2,
        WR_CTRL = 4'd3,
        RUN     = 4'd4,
        CLR_ST  = 4'd5,
        WR_STOP = 4'd6
`ifdef TIMER_HOST_SNAPSHOT_EN
        ,
        SNAP_WR = 4'd7,
        RD_L    = 4'd8,
        RD_H    = 4'd9,
        RD_CAP  = 4'd10
`endif
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] period_q, period_d;
    logic        stop_pend_q, stop_pend_d;
    logic        ign_q, ign_d;
    logic        irq_eff_s;
    logic        busy_q, busy_d;
    logic        tick_q, tick_d;
    logic [15:0] tick_count_q, tick_count_d;
    logic        cs_q, cs_d;
    logic        wn_q, wn_d;
    logic [2:0]  addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
`ifdef TIMER_HOST_SNAPSHOT_EN
    logic [31:0] snap_q, snap_d;
`else
    logic        unused_rdata_s;
`endif

    // Next-state, period latch and pending-stop tracking.
    always_comb begin
        state_d     = state_q;
        period_d    = period_q;
        stop_pend_d = stop_pend_q;
`ifdef TIMER_HOST_SNAPSHOT_EN
        snap_d      = snap_q;
`endif
        // The timer drops irq one cycle after the status clear, so the cycle after CLR_ST is masked.
        irq_eff_s   = irq_in & ~ign_q;
        ign_d       = (state_q == CLR_ST);
        if (stop && (state_q != IDLE)) begin
            stop_pend_d = 1'b1;
        end else begin
            stop_pend_d = stop_pend_q;
        end
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = WR_PL;
                    period_d = period;
                end else begin
                    state_d  = IDLE;
                end
            end
            WR_PL:   state_d = WR_PH;
            WR_PH:   state_d = WR_CTRL;
            WR_CTRL: state_d = RUN;
            RUN: begin
                if (irq_eff_s) begin
                    state_d = CLR_ST;
                end else if (stop_pend_q) begin
                    state_d = WR_STOP;
                end else begin
                    state_d = RUN;
                end
            end
`ifdef TIMER_HOST_SNAPSHOT_EN
            CLR_ST:  state_d = SNAP_WR;
            SNAP_WR: state_d = RD_L;
            RD_L:    state_d = RD_H;
            RD_H: begin
                state_d        = RD_CAP;
                snap_d[15:0]   = avm_readdata;
            end
            RD_CAP: begin
                state_d        = RUN;
                snap_d[31:16]  = avm_readdata;
            end
`else
            CLR_ST:  state_d = RUN;
`endif
            WR_STOP: begin
                state_d     = IDLE;
                stop_pend_d = 1'b0;
            end
            default: begin
                state_d     = IDLE;
                stop_pend_d = 1'b0;
            end
        endcase
    end

    // Bus and status outputs are decoded from the upcoming state so they register in step with it.
    always_comb begin
        cs_d         = 1'b0;
        wn_d         = 1'b1;
        addr_d       = 3'd0;
        wdata_d      = 16'h0000;
        busy_d       = (state_d != IDLE);
        tick_d       = (state_d == CLR_ST);
        if (state_d == CLR_ST) begin
            tick_count_d = tick_count_q + 16'd1;
        end else begin
            tick_count_d = tick_count_q;
        end
        case (state_d)
            WR_PL:   begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd2; wdata_d = period_d[15:0];  end
            WR_PH:   begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd3; wdata_d = period_d[31:16]; end
            WR_CTRL: begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd1; wdata_d = 16'h0007;        end
            CLR_ST:  begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd0; wdata_d = 16'h0000;        end
            WR_STOP: begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd1; wdata_d = 16'h0008;        end
`ifdef TIMER_HOST_SNAPSHOT_EN
            SNAP_WR: begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd4; wdata_d = 16'h0000;        end
            RD_L:    begin cs_d = 1'b1; wn_d = 1'b1; addr_d = 3'd4; wdata_d = 16'h0000;        end
            RD_H:    begin cs_d = 1'b1; wn_d = 1'b1; addr_d = 3'd5; wdata_d = 16'h0000;        end
`endif
            default: begin cs_d = 1'b0; wn_d = 1'b1; addr_d = 3'd0; wdata_d = 16'h0000;        end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            period_q     <= 32'h0000_0000;
            stop_pend_q  <= 1'b0;
            ign_q        <= 1'b0;
            busy_q       <= 1'b0;
            tick_q       <= 1'b0;
            tick_count_q <= 16'h0000;
            cs_q         <= 1'b0;
            wn_q         <= 1'b1;
            addr_q       <= 3'd0;
            wdata_q      <= 16'h0000;
        end else begin
            state_q      <= state_d;
            period_q     <= period_d;
            stop_pend_q  <= stop_pend_d;
            ign_q        <= ign_d;
            busy_q       <= busy_d;
            tick_q       <= tick_d;
            tick_count_q <= tick_count_d;
            cs_q         <= cs_d;
            wn_q         <= wn_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
        end
    end

`ifdef TIMER_HOST_SNAPSHOT_EN
    // Snapshot register, filled half by half from the two counter reads.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            snap_q <= 32'h0000_0000;
        end else begin
            snap_q <= snap_d;
        end
    end
    assign snapshot = snap_q;
`else
    assign unused_rdata_s = ^avm_readdata;
    assign snapshot       = 32'h0000_0000;
`endif

    assign busy           = busy_q;
    assign tick           = tick_q;
    assign tick_count     = tick_count_q;
    assign avm_chipselect = cs_q;
    assign avm_write_n    = wn_q;
    assign avm_address    = addr_q;
    assign avm_writedata  = wdata_q;

endmodule

// File: tb/tb_my_processor_timer_host.sv
// Directed bench for my_processor_timer_host: scoreboard of expected bus accesses plus output checks.
// Snapshot scenarios are included when TIMER_HOST_SNAPSHOT_EN is defined.
module tb_my_processor_timer_host;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        stop;
    logic [31:0] period;
    logic        busy;
    logic        tick;
    logic [15:0] tick_count;
    logic [31:0] snapshot;
    logic [2:0]  avm_address;
    logic        avm_chipselect;
    logic        avm_write_n;
    logic [15:0] avm_writedata;
    logic [15:0] avm_readdata = 16'h0000;
    logic        irq_in;

    int          checks   = 0;
    int          failures = 0;
    logic [19:0] exp_q[$];
    logic [19:0] mon_got;
    logic [19:0] mon_exp;

    my_processor_timer_host dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .stop           (stop),
        .period         (period),
        .busy           (busy),
        .tick           (tick),
        .tick_count     (tick_count),
        .snapshot       (snapshot),
        .avm_address    (avm_address),
        .avm_chipselect (avm_chipselect),
        .avm_write_n    (avm_write_n),
        .avm_writedata  (avm_writedata),
        .avm_readdata   (avm_readdata),
        .irq_in         (irq_in)
    );

    always #5 clk = ~clk;

    // Timer read model: registered data, 0x1234 for address 4 and 0xABCD for address 5.
    always @(posedge clk) begin
        if (avm_chipselect && avm_write_n) begin
            if (avm_address == 3'd4)      avm_readdata <= 16'h1234;
            else if (avm_address == 3'd5) avm_readdata <= 16'hABCD;
            else                          avm_readdata <= 16'h0000;
        end
    end

    // Bus monitor: every access must match the head of the scoreboard; idle cycles must be quiet.
    always @(negedge clk) begin
        mon_got = {avm_write_n, avm_address, avm_writedata};
        if (avm_chipselect === 1'b1) begin
            checks++;
            assert (exp_q.size() > 0) else begin
                failures++;
                $error("FAIL bus_unexpected observed=%h expected=none", mon_got);
            end
            if (exp_q.size() > 0) begin
                mon_exp = exp_q.pop_front();
                assert (mon_got === mon_exp) else begin
                    failures++;
                    $error("FAIL bus_access observed=%h expected=%h", mon_got, mon_exp);
                end
            end
        end else begin
            checks++;
            assert (mon_got === {1'b1, 3'd0, 16'h0000}) else begin
                failures++;
                $error("FAIL bus_idle observed=%h expected=%h", mon_got, {1'b1, 3'd0, 16'h0000});
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_q_empty(input string tag);
        chk(tag, exp_q.size(), 32'd0);
        exp_q.delete();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"},  {31'd0, busy},           32'd0);
        chk({tag, "_tick"},  {31'd0, tick},           32'd0);
        chk({tag, "_tcnt"},  {16'd0, tick_count},     32'd0);
        chk({tag, "_snap"},  snapshot,                32'd0);
        chk({tag, "_cs"},    {31'd0, avm_chipselect}, 32'd0);
        chk({tag, "_wn"},    {31'd0, avm_write_n},    32'd1);
        chk({tag, "_addr"},  {29'd0, avm_address},    32'd0);
        chk({tag, "_wdata"}, {16'd0, avm_writedata},  32'd0);
    endtask

    task automatic push_prog(input logic [31:0] p);
        exp_q.push_back({1'b0, 3'd2, p[15:0]});
        exp_q.push_back({1'b0, 3'd3, p[31:16]});
        exp_q.push_back({1'b0, 3'd1, 16'h0007});
    endtask

    task automatic push_service();
        exp_q.push_back({1'b0, 3'd0, 16'h0000});
`ifdef TIMER_HOST_SNAPSHOT_EN
        exp_q.push_back({1'b0, 3'd4, 16'h0000});
        exp_q.push_back({1'b1, 3'd4, 16'h0000});
        exp_q.push_back({1'b1, 3'd5, 16'h0000});
`endif
    endtask

    // Returns at the negedge where WR_PL is visible on the bus.
    task automatic do_start(input logic [31:0] p);
        period = p;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
    endtask

    task automatic wait_tick(input int bound, input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((tick !== 1'b1) && (n < bound));
        chk(tag, {31'd0, tick}, 32'd1);
    endtask

    task automatic wait_idle(input int bound, input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((busy !== 1'b0) && (n < bound));
        chk(tag, {31'd0, busy}, 32'd0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        exp_q.delete();
    endtask

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        stop    = 1'b0;
        irq_in  = 1'b0;
        period  = 32'h0000_0000;
        repeat (2) @(negedge clk);
        chk_reset_outputs("reset");
        reset_n = 1'b1;
        @(negedge clk);

        // Programming sequence: three consecutive writes, busy from the cycle after start.
        push_prog(32'h0001_86A0);
        do_start(32'h0001_86A0);
        chk("prog_busy", {31'd0, busy}, 32'd1);
        chk("prog_cs0", {31'd0, avm_chipselect}, 32'd1);
        @(negedge clk);
        chk("prog_cs1", {31'd0, avm_chipselect}, 32'd1);
        @(negedge clk);
        chk("prog_cs2", {31'd0, avm_chipselect}, 32'd1);
        @(negedge clk);
        chk("run_cs", {31'd0, avm_chipselect}, 32'd0);
        chk("run_busy", {31'd0, busy}, 32'd1);

        // Start while busy is ignored.
        do_start(32'hDEAD_BEEF);
        @(negedge clk);
        chk_q_empty("start_busy_ignored");

        // IRQ service; irq still high in the masked cycle must not be serviced twice.
        push_service();
        irq_in = 1'b1;
        @(negedge clk);
        chk("irq_tick", {31'd0, tick}, 32'd1);
        chk("irq_tcnt", {16'd0, tick_count}, 32'd1);
`ifdef TIMER_HOST_SNAPSHOT_EN
        irq_in = 1'b0;
        repeat (5) @(negedge clk);
        chk("snap_value", snapshot, 32'hABCD_1234);
`else
        @(negedge clk);
        chk("irq_tick_once", {31'd0, tick}, 32'd0);
        irq_in = 1'b0;
        repeat (2) @(negedge clk);
        chk("snap_tied", snapshot, 32'd0);
`endif
        chk("irq_tcnt_hold", {16'd0, tick_count}, 32'd1);
        chk_q_empty("irq_single_service");

        // IRQ and stop in the same RUN cycle: clear first, then stop.
        push_service();
        exp_q.push_back({1'b0, 3'd1, 16'h0008});
        irq_in = 1'b1;
        stop   = 1'b1;
        @(negedge clk);
        stop   = 1'b0;
        chk("irqstop_tick", {31'd0, tick}, 32'd1);
        @(negedge clk);
        irq_in = 1'b0;
        wait_idle(12, "irqstop_idle");
        chk("irqstop_tcnt", {16'd0, tick_count}, 32'd2);
        chk_q_empty("irqstop_order");

        // Stop in IDLE is ignored: a fresh run must stay running.
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        @(negedge clk);
        push_prog(32'h0000_0010);
        do_start(32'h0000_0010);
        repeat (6) @(negedge clk);
        chk("idle_stop_ignored", {31'd0, busy}, 32'd1);
        chk_q_empty("idle_stop_no_access");
        exp_q.push_back({1'b0, 3'd1, 16'h0008});
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        wait_idle(6, "run_stop_idle");
        chk_q_empty("run_stop_access");

        // Stop during WR_PH: programming completes, then the stop write.
        push_prog(32'h1234_5678);
        exp_q.push_back({1'b0, 3'd1, 16'h0008});
        do_start(32'h1234_5678);
        @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("wrph_stop_ctrl", {29'd0, avm_address}, 32'd1);
        wait_idle(6, "wrph_stop_idle");
        chk_q_empty("wrph_stop_access");

        // Reset in the middle of programming: bus idles at once.
        exp_q.push_back({1'b0, 3'd2, 16'hBEEF});
        exp_q.push_back({1'b0, 3'd3, 16'hCAFE});
        do_start(32'hCAFE_BEEF);
        @(negedge clk);
        #1 reset_n = 1'b0;
        #1 chk_reset_outputs("rst_mid_prog");
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        chk_q_empty("rst_mid_prog_quiet");

`ifdef TIMER_HOST_SNAPSHOT_EN
        // Reset during RD_H.
        push_prog(32'h0000_0100);
        do_start(32'h0000_0100);
        repeat (3) @(negedge clk);
        push_service();
        irq_in = 1'b1;
        wait_tick(8, "snaprst_tick");
        irq_in = 1'b0;
        repeat (3) @(negedge clk);
        #1 reset_n = 1'b0;
        #1 chk_reset_outputs("rst_rd_h");
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk_q_empty("rst_rd_h_quiet");
`endif

        // tick_count wrap: 65535 services reach 0xFFFF, one more wraps to 0.
        do_reset();
        push_prog(32'h0000_0040);
        do_start(32'h0000_0040);
        repeat (3) @(negedge clk);
        irq_in = 1'b1;
        for (int i = 0; i < 65535; i++) begin
            push_service();
            wait_tick(10, "wrap_tick");
        end
        chk("wrap_ffff", {16'd0, tick_count}, 32'h0000_FFFF);
        push_service();
        wait_tick(10, "wrap_last_tick");
        irq_in = 1'b0;
        chk("wrap_zero", {16'd0, tick_count}, 32'h0000_0000);
        repeat (8) @(negedge clk);
        chk_q_empty("wrap_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
